// File: rtl/sr_pkg.sv
// Shared types and constants for the SR flop pulse driver.
package sr_pkg;

  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    GAP   = 2'd2
  } sr_state_e;

endpackage

// File: rtl/sr_pulse_timer.sv
// Down-counting duration timer; done flags the final counted cycle.
module sr_pulse_timer
  import sr_pkg::*;
(
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [CNT_W-1:0] load,
  output logic             done
);

  logic [CNT_W-1:0] cnt;

  // Reload on start, otherwise count down and park at zero.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (start) begin
      cnt <= load;
    end else if (cnt != '0) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign done = (cnt == CNT_W'(1));

endmodule

// File: rtl/sr_driver.sv
// Request-driven set/reset pulse generator for a downstream SR flop.
// Optional SR_DRIVER_SKIP_EN suppresses pulses that would not change level_q.
module sr_driver
  import sr_pkg::*;
#(
  parameter int unsigned PULSE_W = 2,
  parameter int unsigned GAP_W   = 1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic req_valid,
  input  logic req_level,
  output logic req_ready,
  output logic s,
  output logic r,
  output logic level_q,
  output logic busy
);

  localparam bit HAS_GAP = (GAP_W != 0);

  sr_state_e        state_q;
  sr_state_e        state_d;
  logic             lvl_q;
  logic             lvl_d;
  logic             s_d;
  logic             r_d;
  logic             level_d;
  logic             accept;
  logic             skip;
  logic             tmr_start;
  logic [CNT_W-1:0] tmr_load;
  logic             tmr_done;

  assign req_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign accept    = req_valid && req_ready;

`ifdef SR_DRIVER_SKIP_EN
  assign skip = (req_level == level_q);
`else
  assign skip = 1'b0;
`endif

  sr_pulse_timer u_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (tmr_start),
    .load    (tmr_load),
    .done    (tmr_done)
  );

  // Next-state and registered-output decode.
  always_comb begin
    state_d   = state_q;
    lvl_d     = lvl_q;
    level_d   = level_q;
    s_d       = 1'b0;
    r_d       = 1'b0;
    tmr_start = 1'b0;
    tmr_load  = CNT_W'(PULSE_W);
    case (state_q)
      IDLE: begin
        if (accept) begin
          lvl_d = req_level;
          if (!skip) begin
            state_d   = PULSE;
            s_d       = req_level;
            r_d       = !req_level;
            tmr_start = 1'b1;
            tmr_load  = CNT_W'(PULSE_W);
          end
        end
      end
      PULSE: begin
        if (tmr_done) begin
          level_d = lvl_q;
          if (HAS_GAP) begin
            state_d   = GAP;
            tmr_start = 1'b1;
            tmr_load  = CNT_W'(GAP_W);
          end else begin
            state_d = IDLE;
          end
        end else begin
          s_d = lvl_q;
          r_d = !lvl_q;
        end
      end
      GAP: begin
        if (tmr_done) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      lvl_q   <= 1'b0;
      level_q <= 1'b0;
      s       <= 1'b0;
      r       <= 1'b0;
    end else begin
      state_q <= state_d;
      lvl_q   <= lvl_d;
      level_q <= level_d;
      s       <= s_d;
      r       <= r_d;
    end
  end

endmodule

// File: tb/tb_sr_driver.sv
// Scoreboard bench for sr_driver: default timing instance plus a PULSE_W=1/GAP_W=0 instance.
module tb_sr_driver;

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  logic v0 = 1'b0, l0 = 1'b0, v1 = 1'b0, l1 = 1'b0;
  logic rdy0, s0, r0, lq0, busy0;
  logic rdy1, s1, r1, lq1, busy1;

`ifdef SR_DRIVER_SKIP_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  typedef struct {
    int cyc;
    bit s;
    bit r;
    bit lq;
  } rec_t;

  rec_t q0[$];
  rec_t q1[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;
  bit   model0 = 1'b0;
  bit   model1 = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sr_driver #(.PULSE_W(2), .GAP_W(1)) u_std (
    .clk(clk), .reset_n(reset_n), .req_valid(v0), .req_level(l0),
    .req_ready(rdy0), .s(s0), .r(r0), .level_q(lq0), .busy(busy0)
  );

  sr_driver #(.PULSE_W(1), .GAP_W(0)) u_fast (
    .clk(clk), .reset_n(reset_n), .req_valid(v1), .req_level(l1),
    .req_ready(rdy1), .s(s1), .r(r1), .level_q(lq1), .busy(busy1)
  );

  task automatic chk(input string name, input logic [31:0] act, input int exp);
    n_cmp++;
    if (act !== 32'(exp)) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitors: every cycle with s or r high must match the next expected pulse record.
  always @(negedge clk) begin
    rec_t e;
    if (s0 || r0) begin
      if (q0.size() == 0) begin
        chk("std_unexpected_pulse", {30'd0, s0, r0}, 0);
      end else begin
        e = q0.pop_front();
        chk("std_pulse_cycle", cyc, e.cyc);
        chk("std_s", s0, int'(e.s));
        chk("std_r", r0, int'(e.r));
        chk("std_lq_during", lq0, int'(e.lq));
      end
    end
  end

  always @(negedge clk) begin
    rec_t e;
    if (s1 || r1) begin
      if (q1.size() == 0) begin
        chk("fast_unexpected_pulse", {30'd0, s1, r1}, 0);
      end else begin
        e = q1.pop_front();
        chk("fast_pulse_cycle", cyc, e.cyc);
        chk("fast_s", s1, int'(e.s));
        chk("fast_r", r1, int'(e.r));
        chk("fast_lq_during", lq1, int'(e.lq));
      end
    end
  end

  task automatic wait_to(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  // Present a request on the default instance; returns the accept cycle (-1 on timeout).
  task automatic issue0(input bit lvl, input bit hold, input bit track, output int acc);
    bit got = 1'b0;
    v0  = 1'b1;
    l0  = lvl;
    acc = -1;
    for (int k = 0; k < 40; k++) begin
      if (rdy0 === 1'b1) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!got) begin
      chk("std_accept_timeout", 0, 1);
      v0 = 1'b0;
      return;
    end
    acc = cyc;
    if (!(SKIP && (lvl == model0))) begin
      if (track) begin
        for (int i = 1; i <= 2; i++) q0.push_back('{acc + i, lvl, !lvl, model0});
      end
      model0 = lvl;
    end
    @(posedge clk);
    #1;
    if (!hold) v0 = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int a, b, nacc;
    int acc1[6];
    bit got;

    // Asynchronous reset values, before any clock edge
    #1 reset_n = 1'b0;
    #2;
    chk("rst_s", s0, 0);
    chk("rst_r", r0, 0);
    chk("rst_lq", lq0, 0);
    chk("rst_busy", busy0, 0);
    chk("rst_ready", rdy0, 1);
    @(posedge clk);
    @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    chk("ready_after_release", rdy0, 1);

    // Level 0 right after reset
    issue0(1'b0, 1'b0, 1'b1, a);
    chk("lvl0_busy", busy0, SKIP ? 0 : 1);
    chk("lvl0_ready", rdy0, SKIP ? 1 : 0);
    wait_to(a + 5);
    chk("lvl0_drain", q0.size(), 0);
    chk("lvl0_lq", lq0, 0);

    // Set then reset held valid back-to-back
    issue0(1'b1, 1'b1, 1'b1, a);
    issue0(1'b0, 1'b0, 1'b1, b);
    chk("b2b_spacing", b - a, 4);
    wait_to(b + 2);
    chk("b2b_lq_before", lq0, 1);
    wait_to(b + 3);
    chk("b2b_lq_after", lq0, 0);
    wait_to(b + 4);
    chk("b2b_ready", rdy0, 1);
    chk("b2b_drain", q0.size(), 0);

    // Single set: level_q from cycle 3, ready at cycle 4
    issue0(1'b1, 1'b0, 1'b1, a);
    wait_to(a + 2);
    chk("set_lq_c2", lq0, 0);
    wait_to(a + 3);
    chk("set_lq_c3", lq0, 1);
    chk("set_ready_gap", rdy0, 0);
    chk("set_busy_gap", busy0, 1);
    wait_to(a + 4);
    chk("set_ready_c4", rdy0, 1);
    chk("set_busy_c4", busy0, 0);
    chk("set_drain", q0.size(), 0);

    // Same level requested again
    issue0(1'b1, 1'b0, 1'b1, a);
    chk("same_busy", busy0, SKIP ? 0 : 1);
    wait_to(a + 5);
    chk("same_drain", q0.size(), 0);
    chk("same_lq", lq0, 1);

    // Reset asserted during the first PULSE cycle
    issue0(1'b0, 1'b0, 1'b0, a);
    chk("abort_r_before", r0, 1);
    chk("abort_lq_before", lq0, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("abort_s", s0, 0);
    chk("abort_r", r0, 0);
    chk("abort_lq", lq0, 0);
    chk("abort_busy", busy0, 0);
    model0 = 1'b0;
    model1 = 1'b0;
    @(posedge clk);
    #1 reset_n = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_ready_after", rdy0, 1);
    chk("abort_busy_after", busy0, 0);
    repeat (4) @(negedge clk);
    chk("abort_lq_after", lq0, 0);

    // PULSE_W=1, GAP_W=0 with continuous alternating requests
    nacc = 0;
    v1 = 1'b1;
    l1 = 1'b1;
    for (int k = 0; k < 6; k++) begin
      got = 1'b0;
      for (int j = 0; j < 20; j++) begin
        if (rdy1 === 1'b1) begin
          got = 1'b1;
          break;
        end
        @(negedge clk);
      end
      if (!got) begin
        chk("fast_accept_timeout", 0, 1);
        break;
      end
      acc1[k] = cyc;
      nacc++;
      q1.push_back('{cyc + 1, l1, !l1, model1});
      model1 = l1;
      @(posedge clk);
      #1 l1 = !l1;
    end
    v1 = 1'b0;
    for (int k = 1; k < nacc; k++) chk("fast_spacing", acc1[k] - acc1[k-1], 2);
    repeat (3) @(negedge clk);
    chk("fast_drain", q1.size(), 0);
    chk("fast_lq", lq1, int'(model1));
    chk("std_idle_drain", q0.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
